// File: rtl/sap_memory_unit.sv
// sap_memory_unit: memory stage of the 8-bit CPU.
// Holds the MAR, the MDR and a 2^ADDR_W x DATA_W RAM. In normal operation the
// control block's active-low strobes load MAR/MDR, write RAM[MAR] from MDR, or
// put RAM[MAR] on the shared bus. A byte-wide loader port with a valid/ready
// handshake can take ownership of the RAM and fill it sequentially from
// address 0 before the CPU runs.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   bus_in             shared bus value (MAR takes the low ADDR_W bits)
//   mar_addr_load_n    low: MAR <= bus_in
//   mar_mem_load_n     low: MDR <= bus_in
//   ram_en_n           low: RAM[MAR] drives the bus (combinational)
//   ram_load_n         low: RAM[MAR] <= MDR
//   bus_out/bus_drive  read data (0 when not driving) and drive enable
//   mar_q, mdr_q       current MAR / MDR
//   ctrl_err           sticky flag: read and write strobed together
//   prog_mode          high: loader owns the RAM
//   prog_valid/data    loader byte handshake (input side)
//   prog_ready         loader byte is accepted on this edge when high
//   prog_done          every RAM word has been loaded
//   prog_count         words written in the current/last load
//
// state | meaning
// IDLE  | CPU owns RAM; control strobes active
// LOAD  | loader owns RAM; accepting bytes
// DONE  | all words loaded; waiting for prog_mode to drop
module sap_memory_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              ctrl_err,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_d;
  logic              ctrl_err_q, ctrl_err_d;
  logic              prog_ready_q, prog_ready_d;
  logic              prog_done_q, prog_done_d;
  logic [ADDR_W:0]   prog_count_q, prog_count_d;

  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              last_word;

  // The load pointer and the word count are the same quantity; the low bits
  // address the RAM, the extra bit lets the count reach 2^ADDR_W.
  assign last_word = (prog_count_q[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    ctrl_err_d   = ctrl_err_q;
    prog_ready_d = prog_ready_q;
    prog_done_d  = prog_done_q;
    prog_count_d = prog_count_q;
    ram_we       = 1'b0;
    ram_waddr    = mar_q;
    ram_wdata    = mdr_q;
    unique case (state_q)
      IDLE: begin
        if (!mar_addr_load_n) mar_d = bus_in[ADDR_W-1:0];
        if (!mar_mem_load_n)  mdr_d = bus_in;
        // Write uses pre-edge MAR/MDR; a simultaneous read makes it illegal.
        if (!ram_load_n) begin
          if (ram_en_n) ram_we = 1'b1;
          else          ctrl_err_d = 1'b1;
        end
        if (prog_mode) begin
          state_d      = LOAD;
          prog_ready_d = 1'b1;
          prog_done_d  = 1'b0;
          prog_count_d = '0;
        end
      end
      LOAD: begin
        // Dropping prog_mode aborts; it wins over a byte offered on that edge.
        if (!prog_mode) begin
          state_d      = IDLE;
          prog_ready_d = 1'b0;
        end else if (prog_valid && prog_ready_q) begin
          ram_we       = 1'b1;
          ram_waddr    = prog_count_q[ADDR_W-1:0];
          ram_wdata    = prog_data;
          prog_count_d = prog_count_q + 1'b1;
          if (last_word) begin
            state_d      = DONE;
            prog_ready_d = 1'b0;
            prog_done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!prog_mode) state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        prog_ready_d = 1'b0;
      end
    endcase
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mar_q        <= '0;
      mdr_q        <= '0;
      ctrl_err_q   <= 1'b0;
      prog_ready_q <= 1'b0;
      prog_done_q  <= 1'b0;
      prog_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      ctrl_err_q   <= ctrl_err_d;
      prog_ready_q <= prog_ready_d;
      prog_done_q  <= prog_done_d;
      prog_count_q <= prog_count_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
  end

  assign bus_drive  = !rst && (state_q == IDLE) && !ram_en_n;
  assign bus_out    = bus_drive ? ram_mem[mar_q] : '0;
  assign ctrl_err   = ctrl_err_q;
  assign prog_ready = prog_ready_q;
  assign prog_done  = prog_done_q;
  assign prog_count = prog_count_q;

endmodule

// File: tb/tb_sap_memory_unit.sv
// Testbench for sap_memory_unit: directed stimulus, a behavioural model
// checked every falling edge, and hand-computed literal expectations.
module tb_sap_memory_unit;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic [3:0] mar_q;
  logic [7:0] mdr_q;
  logic       ctrl_err;
  logic       prog_mode, prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready, prog_done;
  logic [4:0] prog_count;

  int n_checks = 0;
  int n_fail   = 0;

  sap_memory_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .mar_addr_load_n(mar_addr_load_n), .mar_mem_load_n(mar_mem_load_n),
    .ram_en_n(ram_en_n), .ram_load_n(ram_load_n),
    .bus_out(bus_out), .bus_drive(bus_drive), .mar_q(mar_q), .mdr_q(mdr_q),
    .ctrl_err(ctrl_err), .prog_mode(prog_mode), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_ready(prog_ready), .prog_done(prog_done),
    .prog_count(prog_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the RAM, and what the RAM/registers hold.
  int m_owner = 0;   // 0 = CPU, 1 = loader taking bytes, 2 = loader finished
  int m_mem [16];
  bit m_known [16];
  int m_mar = 0, m_mdr = 0, m_count = 0;
  bit m_err = 0, m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_mar = 0; m_mdr = 0; m_count = 0; m_err = 0; m_done = 0;
    end else begin
      case (m_owner)
        0: begin
          if (!ram_load_n && ram_en_n) begin
            m_mem[m_mar] = m_mdr;
            m_known[m_mar] = 1;
          end
          if (!ram_load_n && !ram_en_n) m_err = 1;
          if (!mar_addr_load_n) m_mar = bus_in % 16;
          if (!mar_mem_load_n)  m_mdr = bus_in;
          if (prog_mode) begin m_owner = 1; m_count = 0; m_done = 0; end
        end
        1: begin
          if (!prog_mode) m_owner = 0;
          else if (prog_valid) begin
            m_mem[m_count] = prog_data;
            m_known[m_count] = 1;
            m_count++;
            if (m_count == 16) begin m_owner = 2; m_done = 1; end
          end
        end
        default: if (!prog_mode) m_owner = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    bit exp_drive;
    exp_drive = !rst && (m_owner == 0) && !ram_en_n;
    chk("mdl_mar",        mar_q,      m_mar);
    chk("mdl_mdr",        mdr_q,      m_mdr);
    chk("mdl_ctrl_err",   ctrl_err,   m_err);
    chk("mdl_prog_ready", prog_ready, m_owner == 1);
    chk("mdl_prog_done",  prog_done,  m_done);
    chk("mdl_prog_count", prog_count, m_count);
    chk("mdl_bus_drive",  bus_drive,  exp_drive);
    if (!exp_drive) chk("mdl_bus_out", bus_out, 0);
    else if (m_known[m_mar]) chk("mdl_bus_out", bus_out, m_mem[m_mar]);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input int a, input int exp, input string name);
    bus_in = 8'(a);
    mar_addr_load_n = 1'b0;
    step();
    mar_addr_load_n = 1'b1;
    ram_en_n = 1'b0;
    #1;
    chk(name, bus_out, exp);
    chk({name, "_drive"}, bus_drive, 1);
    ram_en_n = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_in = 8'h00;
    mar_addr_load_n = 1'b1; mar_mem_load_n = 1'b1;
    ram_en_n = 1'b1; ram_load_n = 1'b1;
    prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_mar", mar_q, 0);
    chk("rst_mdr", mdr_q, 0);
    chk("rst_err", ctrl_err, 0);
    chk("rst_ready", prog_ready, 0);
    chk("rst_done", prog_done, 0);
    chk("rst_count", prog_count, 0);
    chk("rst_out", bus_out, 0);

    // Full load, valid already high before ready rises.
    prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'h10;
    #1;
    chk("load_ready_before_edge", prog_ready, 0);
    step();
    chk("load_ready_rises", prog_ready, 1);
    chk("load_no_early_count", prog_count, 0);
    for (int k = 0; k < 16; k++) begin
      prog_data = 8'(8'h10 + k);
      step();
      chk("load_count", prog_count, k + 1);
    end
    chk("load_done", prog_done, 1);
    chk("load_ready_low", prog_ready, 0);
    prog_data = 8'hEE;
    step();
    chk("done_blocks_count", prog_count, 16);
    prog_mode = 1'b0; prog_valid = 1'b0;
    step();
    chk("idle_done_held", prog_done, 1);
    chk("idle_count_held", prog_count, 16);

    // Read.
    rd(5, 8'h15, "read_5");
    chk("read_mar", mar_q, 5);
    #1;
    chk("read_off", bus_out, 0);
    rd(0, 8'h10, "read_0");
    rd(15, 8'h1F, "read_15");

    // Write and readback.
    bus_in = 8'h03; mar_addr_load_n = 1'b0; step();
    mar_addr_load_n = 1'b1; bus_in = 8'hA5; mar_mem_load_n = 1'b0; step();
    mar_mem_load_n = 1'b1; ram_load_n = 1'b0; step();
    ram_load_n = 1'b1; ram_en_n = 1'b0; #1;
    chk("wr_readback", bus_out, 8'hA5);
    ram_en_n = 1'b1;
    bus_in = 8'h5A; mar_mem_load_n = 1'b0; step();
    mar_mem_load_n = 1'b1;
    bus_in = 8'h07; mar_addr_load_n = 1'b0; ram_load_n = 1'b0; step();
    mar_addr_load_n = 1'b1; ram_load_n = 1'b1;
    chk("same_edge_mar", mar_q, 7);
    ram_en_n = 1'b0; #1;
    chk("same_edge_addr7_untouched", bus_out, 8'h17);
    ram_en_n = 1'b1;
    rd(3, 8'h5A, "same_edge_addr3");

    // Conflicting read and write.
    bus_in = 8'h04; mar_addr_load_n = 1'b0; step();
    mar_addr_load_n = 1'b1; bus_in = 8'h33; mar_mem_load_n = 1'b0; step();
    mar_mem_load_n = 1'b1;
    ram_en_n = 1'b0; ram_load_n = 1'b0; #1;
    chk("conflict_read", bus_out, 8'h14);
    step();
    ram_load_n = 1'b1; #1;
    chk("conflict_err", ctrl_err, 1);
    chk("conflict_no_write", bus_out, 8'h14);
    ram_en_n = 1'b1;
    step(); step();
    chk("err_sticky", ctrl_err, 1);

    // Gapped load, then abort.
    prog_mode = 1'b1; step();
    chk("reenter_done_clr", prog_done, 0);
    chk("reenter_count_clr", prog_count, 0);
    for (int i = 0; i < 10; i++) begin
      prog_valid = (i % 2 == 0);
      prog_data = 8'(8'h40 + i / 2);
      step();
    end
    chk("gap_count", prog_count, 5);
    prog_valid = 1'b0; prog_mode = 1'b0; step();
    chk("abort_ready", prog_ready, 0);
    chk("abort_count", prog_count, 5);
    chk("abort_done", prog_done, 0);
    for (int k = 0; k < 5; k++) rd(k, 8'h40 + k, "gap_read");
    rd(5, 8'h15, "gap_read_5");

    // Re-enter, controls ignored while loading, async reset mid-load.
    prog_mode = 1'b1; step();
    chk("reload_count", prog_count, 0);
    chk("reload_ready", prog_ready, 1);
    prog_valid = 1'b1;
    bus_in = 8'h09; mar_addr_load_n = 1'b0; mar_mem_load_n = 1'b0; ram_en_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      prog_data = 8'(8'h60 + j);
      step();
      chk("loading_no_drive", bus_drive, 0);
    end
    mar_addr_load_n = 1'b1; mar_mem_load_n = 1'b1; ram_en_n = 1'b1;
    chk("loading_mar_held", mar_q, 5);
    chk("reload_count3", prog_count, 3);
    rst = 1'b1; #1;
    chk("async_ready", prog_ready, 0);
    chk("async_count", prog_count, 0);
    chk("async_err", ctrl_err, 0);
    prog_mode = 1'b0; prog_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    rd(0, 8'h60, "kept_0");
    rd(2, 8'h62, "kept_2");
    rd(3, 8'h43, "kept_3");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
